// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, data width and frame-length helper.
// Reused by the transmit framer and the receiver.
package uart_pkg;

   localparam int UART_DATA_BITS   = 8;
   localparam int UART_START_BITS  = 1;
   localparam int UART_PARITY_BITS = 1;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   function automatic int uart_frame_bits(input int stop_bits, input bit parity_en);
      return UART_START_BITS + UART_DATA_BITS + (parity_en ? UART_PARITY_BITS : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/baud_edge_sync.sv
// Two-flop synchronizer on baud_clk plus rising-edge detect; bit_tick is a one-cycle
// pulse 3 clocks after a baud_clk rise. No backpressure: ticks are never held off.
module baud_edge_sync (
   input  logic clock,
   input  logic reset_n,
   input  logic baud_clk,
   output logic bit_tick
);

   logic sync_1;
   logic sync_2;
   logic sync_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_1   <= 1'b0;
         sync_2   <= 1'b0;
         sync_d   <= 1'b0;
         bit_tick <= 1'b0;
      end else begin
         sync_1   <= baud_clk;
         sync_2   <= sync_1;
         sync_d   <= sync_2;
         bit_tick <= sync_2 & ~sync_d;
      end
   end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, 8 data bits LSB first, parity when UART_TX_PARITY_EN is defined,
// STOP_BITS stop bits; registered tx_out, one bit per baud tick; tx_start ignored while busy.
module uart_tx_framer #(
   parameter int STOP_BITS = 1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       baud_clk,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   input  logic       parity_odd,
   output logic       tx_out,
   output logic       busy,
   output logic       done
);

   import uart_pkg::*;

   // Only the last stop-bit index matters; 1 or 2 stop bits fit in one counter bit.
   localparam logic STOP_LAST = (STOP_BITS == 2);

   uart_state_t               state, state_n;
   logic [2:0]                bit_idx, bit_idx_n;
   logic                      stop_cnt, stop_cnt_n;
   logic [UART_DATA_BITS-1:0] data_q, data_n;
   logic                      tx_out_n, busy_n, done_n;
   logic                      bit_tick;

`ifdef UART_TX_PARITY_EN
   logic par_q, par_n;
`else
   logic parity_unused;
   assign parity_unused = parity_odd;
`endif

   baud_edge_sync u_sync (
      .clock    (clock),
      .reset_n  (reset_n),
      .baud_clk (baud_clk),
      .bit_tick (bit_tick)
   );

   always_comb begin
      state_n    = state;
      bit_idx_n  = bit_idx;
      stop_cnt_n = stop_cnt;
      data_n     = data_q;
      tx_out_n   = tx_out;
      busy_n     = busy;
      done_n     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_n      = par_q;
`endif
      case (state)
         IDLE: begin
            tx_out_n = 1'b1;
            if (tx_start) begin
               data_n     = tx_data;
`ifdef UART_TX_PARITY_EN
               par_n      = (^tx_data) ^ parity_odd;
`endif
               bit_idx_n  = 3'd0;
               stop_cnt_n = 1'b0;
               busy_n     = 1'b1;
               state_n    = ARM;
            end
         end
         ARM: begin
            tx_out_n = 1'b1;
            if (bit_tick) begin
               tx_out_n = 1'b0;
               state_n  = START;
            end
         end
         START: begin
            if (bit_tick) begin
               tx_out_n = data_q[bit_idx];
               state_n  = DATA;
            end
         end
         DATA: begin
            if (bit_tick) begin
               // Index wraps 7->0 so it is already clear for the next frame.
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_out_n = par_q;
                  state_n  = PARITY;
`else
                  tx_out_n   = 1'b1;
                  stop_cnt_n = 1'b0;
                  state_n    = STOP;
`endif
               end else begin
                  tx_out_n = data_q[bit_idx + 3'd1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_tick) begin
               tx_out_n   = 1'b1;
               stop_cnt_n = 1'b0;
               state_n    = STOP;
            end
         end
`endif
         STOP: begin
            tx_out_n = 1'b1;
            if (bit_tick) begin
               if (stop_cnt == STOP_LAST) begin
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  state_n = IDLE;
               end else begin
                  stop_cnt_n = stop_cnt + 1'b1;
               end
            end
         end
         default: begin
            tx_out_n = 1'b1;
            busy_n   = 1'b0;
            state_n  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         bit_idx  <= 3'd0;
         stop_cnt <= 1'b0;
         data_q   <= '0;
         tx_out   <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         bit_idx  <= bit_idx_n;
         stop_cnt <= stop_cnt_n;
         data_q   <= data_n;
         tx_out   <= tx_out_n;
         busy     <= busy_n;
         done     <= done_n;
`ifdef UART_TX_PARITY_EN
         par_q    <= par_n;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: expected frames queued at acceptance,
// a line monitor checks every bit time, busy/done, and the end-of-frame done pulse.
module tb_uart_tx_framer;

   localparam int SB = 1;
   localparam int P  = 20;
`ifdef UART_TX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int FRAME_BITS = 1 + 8 + PAR_BITS + SB;
   localparam int LIMIT = 3000;

   typedef logic [15:0] frame_t;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       baud_clk = 1'b0;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       parity_odd = 1'b0;
   logic       tx_out, busy, done;

   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   int     done_seen = 0;
   int     exp_done = 0;
   bit     in_frame = 1'b0;
   frame_t exp_q[$];
   int     start_cyc[$];

   uart_tx_framer #(.STOP_BITS(SB)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .baud_clk   (baud_clk),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .parity_odd (parity_odd),
      .tx_out     (tx_out),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   initial begin
      #3;
      forever #100 baud_clk = ~baud_clk;
   end

   always @(posedge clock) cyc <= cyc + 1;
   always @(negedge clock) if (done === 1'b1) done_seen <= done_seen + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   task automatic chk_wait(input string name, input int waited);
      checks++;
      if (waited >= LIMIT) begin
         errors++;
         $display("FAIL %s waited %0d cycles, limit %0d", name, waited, LIMIT);
      end
   endtask

   // Line image, LSB = first bit on the wire; unused upper bits stay 1 (stop level).
   function automatic frame_t make_frame(input logic [7:0] d, input logic po);
      frame_t f = '1;
      int n = 0;
      f[n] = 1'b0;
      n = n + 1;
      for (int i = 0; i < 8; i++) begin
         f[n] = d[i];
         n = n + 1;
      end
`ifdef UART_TX_PARITY_EN
      f[n] = (^d) ^ po;
`else
      f[n] = 1'b1 | po;
`endif
      return f;
   endfunction

   task automatic send(input logic [7:0] d, input logic po, input bit noise);
      int w = 0;
      @(negedge clock);
      while (busy !== 1'b0 && w < LIMIT) begin
         @(negedge clock);
         w++;
      end
      chk_wait("send_wait_idle", w);
      tx_start = 1'b1;
      tx_data = d;
      parity_odd = po;
      exp_q.push_back(make_frame(d, po));
      exp_done++;
      @(posedge clock);
      #1 tx_start = 1'b0;
      if (noise) begin
         for (int c = 0; c < (FRAME_BITS + 3) * P; c++) begin
            @(negedge clock);
            if (busy !== 1'b1) break;
            if ($urandom_range(0, 3) == 0) begin
               tx_start = 1'b1;
               tx_data = 8'($urandom);
               parity_odd = 1'($urandom);
            end else begin
               tx_start = 1'b0;
            end
         end
         tx_start = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int w = 0;
      do begin
         @(negedge clock);
         w++;
      end while ((busy !== 1'b0 || exp_q.size() != 0 || in_frame) && w < LIMIT);
      chk_wait("frame_complete", w);
   endtask

   initial begin : monitor
      frame_t     f;
      logic       mism;
      logic       aborted;
      logic [1:0] ctl_seen;
      forever begin
         @(negedge clock);
         if (reset_n === 1'b1 && tx_out === 1'b0) begin
            in_frame = 1'b1;
            start_cyc.push_back(cyc);
            chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) f = exp_q.pop_front();
            else f = '1;
            aborted = 1'b0;
            ctl_seen = 2'b10;
            for (int k = 0; k < FRAME_BITS && !aborted; k++) begin
               mism = f[k];
               for (int c = 0; c < P; c++) begin
                  if (k != 0 || c != 0) @(negedge clock);
                  if (reset_n !== 1'b1) begin
                     aborted = 1'b1;
                     break;
                  end
                  if (tx_out !== f[k]) mism = tx_out;
                  if ({busy, done} !== 2'b10) ctl_seen = {busy, done};
               end
               if (!aborted) chk($sformatf("frame_bit%0d", k), 32'(mism), 32'(f[k]));
            end
            if (!aborted) begin
               chk("busy_done_in_frame", 32'(ctl_seen), 32'h2);
               @(negedge clock);
               if (reset_n === 1'b1) chk("done_at_frame_end", 32'({busy, done}), 32'h1);
            end
            in_frame = 1'b0;
         end
      end
   end

   initial begin : stim
      int w;
      int n;
      logic [7:0] d;
      logic po;
      bit nz;

      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (i % 8 == 0) chk("reset_hold", 32'({tx_out, busy, done}), 32'h4);
      end
      @(posedge clock);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 3 * P; i++) begin
         @(negedge clock);
         if (i % 10 == 0) chk("idle_after_reset", 32'({tx_out, busy, done}), 32'h4);
      end

      send(8'hA5, 1'b0, 1'b0);
      wait_idle();
      send(8'h03, 1'b0, 1'b0);
      wait_idle();
      send(8'h03, 1'b1, 1'b0);
      wait_idle();
      send(8'hC3, 1'b1, 1'b1);
      wait_idle();

      // Back-to-back: second request lands in the done cycle.
      send(8'h3C, 1'b0, 1'b0);
      w = 0;
      do begin
         @(negedge clock);
         w++;
      end while (done !== 1'b1 && w < LIMIT);
      chk_wait("b2b_done", w);
      tx_start = 1'b1;
      tx_data = 8'h5A;
      parity_odd = 1'b1;
      exp_q.push_back(make_frame(8'h5A, 1'b1));
      exp_done++;
      @(posedge clock);
      #1 tx_start = 1'b0;
      wait_idle();
      n = start_cyc.size();
      if (n >= 2) chk("b2b_start_gap", 32'(start_cyc[n-1] - start_cyc[n-2]), 32'((FRAME_BITS + 1) * P));
      else chk("b2b_frames_seen", 32'(n), 32'd2);

      // Abort during data bit 4 (bit 4 of 8'hE7 is 0).
      send(8'hE7, 1'b0, 1'b0);
      w = 0;
      do begin
         @(negedge clock);
         w++;
      end while (tx_out !== 1'b0 && w < LIMIT);
      chk_wait("abort_frame_start", w);
      repeat (5 * P + P / 2) @(posedge clock);
      #1;
      chk("bit4_before_reset", 32'(tx_out), 32'd0);
      reset_n = 1'b0;
      exp_done--;
      #1;
      chk("reset_tx_out", 32'(tx_out), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         chk("reset_no_done", 32'(done), 32'd0);
      end
      @(posedge clock);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 2 * P; i++) begin
         @(negedge clock);
         if (i % 5 == 0) chk("post_abort_idle", 32'({tx_out, busy, done}), 32'h4);
      end
      send(8'h96, 1'b1, 1'b0);
      wait_idle();

      for (int r = 0; r < 8; r++) begin
         d = 8'($urandom);
         po = 1'($urandom);
         nz = ($urandom_range(0, 1) == 1);
         send(d, po, nz);
         if ($urandom_range(0, 2) != 0) wait_idle();
         repeat ($urandom_range(0, 15)) @(negedge clock);
      end
      wait_idle();

      repeat (3) @(negedge clock);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("done_count", 32'(done_seen), 32'(exp_done));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #600000;
      errors++;
      $display("FAIL watchdog simulation did not complete, cycle=%0d", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter STOP_BITS, default 1, number of stop bits per frame (legal values 1 or 2).
REQ-002 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port baud_clk  input  1  square-wave bit clock from the baud generator; one full period = one bit time.
REQ-005 SHALL have port tx_start  input  1  request to send tx_data; sampled only when busy=0.
REQ-006 SHALL have port tx_data  input  8  byte to transmit.
REQ-007 SHALL have port parity_odd  input  1  parity sense: 1 = odd, 0 = even; sampled together with tx_data.
REQ-008 SHALL have port tx_out  output  1  serial line; idle high.
REQ-009 SHALL have port busy  output  1  high from acceptance until the frame completes.
REQ-010 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 SHALL pass baud_clk through a 2-flop synchronizer and generate bit_tick, a one-clock pulse on each synchronized rising edge (3-cycle latency).
REQ-012 SHALL implement states IDLE, ARM, START, DATA, PARITY, STOP.
REQ-013 SHALL, in IDLE with tx_start=1, latch tx_data and parity_odd, set busy=1 on the next cycle, and enter ARM.
REQ-014 SHALL ignore tx_start while busy=1; the latched data SHALL NOT change mid-frame.
REQ-015 SHALL leave ARM on the first bit_tick and enter START, driving tx_out=0 (registered) for one bit time.
REQ-016 SHALL on each subsequent bit_tick advance: START->DATA; in DATA shift out bits LSB first, using a 3-bit index that wraps 7->0 while exiting DATA after bit 7.
REQ-017 SHALL after DATA enter PARITY when parity is compiled in (REQ-024); otherwise go directly to STOP.
REQ-018 SHALL drive tx_out=1 in STOP for STOP_BITS bit times, then enter IDLE.
REQ-019 SHALL assert done for exactly the first IDLE cycle after STOP, with busy=0 in that same cycle.
REQ-020 SHALL accept a tx_start asserted during the done cycle (back-to-back frames), so the next frame has no extra idle bit beyond ARM alignment.
REQ-021 SHALL hold tx_out=1 in IDLE and ARM.
REQ-022 SHALL NOT allow bit_tick to advance more than one bit per tick; if baud_clk stops, the state SHALL hold indefinitely.

Reset
REQ-023 SHALL on reset_n=0, immediately and asynchronously set tx_out=1, busy=0, done=0, state=IDLE, bit index=0, and clear synchronizer/edge flops; a frame in flight is aborted with no completion pulse.

Configuration
REQ-024 SHALL, with macro UART_TX_PARITY_EN defined, insert a PARITY state after DATA that drives XOR of the latched byte XOR parity_odd, making the frame 1+8+1+STOP_BITS bits.
REQ-025 SHALL, without UART_TX_PARITY_EN, omit the PARITY state and parity logic and ignore parity_odd, making the frame 1+8+STOP_BITS bits.

Structure
REQ-026 SHALL place the state encoding, UART_DATA_BITS=8 and the frame-length constants in shared package uart_pkg, reused by the receiver.
REQ-027 SHALL implement the synchronizer plus rising-edge detect as sub-module baud_edge_sync (ports clock, reset_n, baud_clk, bit_tick).

Verification
REQ-028 SHALL check: reset held, then released with baud_clk toggling -> tx_out=1, busy=0, done=0 throughout, with no tx_start.
REQ-029 SHALL check: baud_clk period 20 clocks, tx_data=8'hA5, parity off, STOP_BITS=1 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, with each bit 20 clocks long and done pulsing once.
REQ-030 SHALL check: UART_TX_PARITY_EN, tx_data=8'h03, parity_odd=0 -> parity bit 0; with parity_odd=1 -> parity bit 1.
REQ-031 SHALL check: tx_start pulses repeatedly mid-frame with varying tx_data -> frame bits unchanged and exactly one done pulse.
REQ-032 SHALL check: tx_start asserted in the done cycle with 8'h5A -> second start bit begins at the next bit_tick after ARM.
REQ-033 SHALL check: reset_n dropped during DATA bit 4 -> tx_out=1 and busy=0 in the same cycle, no done pulse, and the next frame is correct.
